// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampled UART receiver, 8 data bits LSB first, optional parity
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       rst_n,
  input  logic [1:0] parity_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int c_M  = OVERSAMPLE / 2;
  localparam int c_TW = $clog2(OVERSAMPLE);
  localparam logic [c_TW-1:0] c_TICK_ONE  = c_TW'(1);
  localparam logic [c_TW-1:0] c_TICK_PRE  = c_TW'(c_M - 1);
  localparam logic [c_TW-1:0] c_TICK_MID  = c_TW'(c_M);
  localparam logic [c_TW-1:0] c_TICK_DEC  = c_TW'(c_M + 1);
  localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rxs_prev;
  logic [c_TW-1:0] r_tick;
  logic [2:0]      r_bit_idx;
  logic            r_vote_a;
  logic            r_vote_b;
  logic [7:0]      r_shift;
  logic [1:0]      r_par_mode;
  logic            r_par_err;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_perr;
  logic            r_ferr;

  logic w_rxs;
  logic w_fall;
  logic w_at_dec;
  logic w_at_last;
  logic w_vote;
  logic w_par_on;
  logic w_par_exp;

  assign w_rxs     = r_sync2;
  assign w_fall    = r_rxs_prev & ~w_rxs;
  assign w_at_dec  = (r_tick == c_TICK_DEC);
  assign w_at_last = (r_tick == c_TICK_LAST);
  // Two earlier samples are held; the third is the live synchronized level.
  assign w_vote    = (r_vote_a & r_vote_b) | (r_vote_a & w_rxs) | (r_vote_b & w_rxs);
  assign w_par_on  = (r_par_mode == 2'd1) || (r_par_mode == 2'd2);
  assign w_par_exp = (r_par_mode == 2'd1) ? ~^r_shift : ^r_shift;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_next = S_START;
      end
      S_START: begin
        if (w_at_dec && w_vote) w_state_next = S_IDLE;
        else if (w_at_last)     w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_at_last && (r_bit_idx == 3'd7))
          w_state_next = w_par_on ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_at_last) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_at_dec) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rxs_prev <= 1'b1;
      r_tick     <= '0;
      r_bit_idx  <= '0;
      r_vote_a   <= 1'b1;
      r_vote_b   <= 1'b1;
      r_shift    <= '0;
      r_par_mode <= '0;
      r_par_err  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_sync1    <= rx_i;
      r_sync2    <= r_sync1;
      r_rxs_prev <= r_sync2;
      r_valid    <= 1'b0;

      // The edge cycle itself counts as tick 0 of the start bit.
      if (r_state == S_IDLE)
        r_tick <= w_fall ? c_TICK_ONE : '0;
      else if ((w_state_next != r_state) || w_at_last)
        r_tick <= '0;
      else
        r_tick <= r_tick + 1'b1;

      if (r_tick == c_TICK_PRE) r_vote_a <= w_rxs;
      if (r_tick == c_TICK_MID) r_vote_b <= w_rxs;

      case (r_state)
        S_START: begin
          if (w_at_dec && !w_vote) begin
            r_par_mode <= parity_i;
            r_bit_idx  <= '0;
            r_par_err  <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_at_dec)  r_shift   <= {w_vote, r_shift[7:1]};
          if (w_at_last) r_bit_idx <= r_bit_idx + 3'd1;
        end
        S_PARITY: begin
          if (w_at_dec) r_par_err <= (w_vote != w_par_exp);
        end
        S_STOP: begin
          if (w_at_dec) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
            r_perr  <= r_par_err;
            r_ferr  <= ~w_vote;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign parity_err_o = r_perr;
  assign frame_err_o  = r_ferr;
  assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx driven by directed and random frames
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic       baud_clk = 1'b0;
  logic       rst_n;
  logic [1:0] parity_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       busy_o;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .baud_clk     (baud_clk),
    .rst_n        (rst_n),
    .parity_i     (parity_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         edge_cyc;
    int         nbits;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   hold_shown = 0;
  logic [7:0] hold_data = 8'h00;
  logic hold_perr = 1'b0;
  logic hold_ferr = 1'b0;
  bit   prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    repeat (OS) @(posedge baud_clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'b1);
  endtask

  // Reference: expected outcome derived from the frame contents alone.
  task automatic send_frame(input logic [7:0] b, input logic [1:0] mode, input logic pbit,
                            input logic stopv, input bit chg);
    exp_t e;
    int   ones;
    bit   has_par;
    has_par    = (mode == 2'd1) || (mode == 2'd2);
    ones       = $countones({b, pbit});
    e.data     = b;
    e.ferr     = !stopv;
    e.perr     = has_par && ((mode == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1));
    e.nbits    = has_par ? 10 : 9;
    e.edge_cyc = cyc + 1;
    parity_i   = mode;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      if (chg && i == 0) parity_i = 2'($urandom_range(0, 3));
    end
    if (has_par) drive_bit(pbit);
    drive_bit(stopv);
  endtask

  // Monitor: pops the scoreboard on every valid_o and checks hold otherwise.
  initial begin
    exp_t e;
    int   lat;
    int   want;
    forever begin
      @(negedge baud_clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else if (valid_o) begin
        check("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (sb.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_valid: got data 0x%0h, want no frame", data_o);
        end else begin
          e = sb.pop_front();
          check("data", 32'(data_o), 32'(e.data));
          check("parity_err", 32'(parity_err_o), 32'(e.perr));
          check("frame_err", 32'(frame_err_o), 32'(e.ferr));
          lat  = cyc - e.edge_cyc;
          want = 2 + e.nbits * OS + M + 1;
          tests++;
          if (lat < want - 1 || lat > want + 1) begin
            failed++;
            $display("FAIL latency: got %0d, want %0d +/-1", lat, want);
          end
          hold_data = e.data;
          hold_perr = e.perr;
          hold_ferr = e.ferr;
        end
        prev_valid = 1'b1;
      end else begin
        prev_valid = 1'b0;
        tests++;
        if ({data_o, parity_err_o, frame_err_o} !== {hold_data, hold_perr, hold_ferr}) begin
          failed++;
          if (hold_shown < 5) begin
            hold_shown++;
            $display("FAIL output_hold: got 0x%0h/%0b/%0b, want 0x%0h/%0b/%0b",
                     data_o, parity_err_o, frame_err_o, hold_data, hold_perr, hold_ferr);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    tests++;
    failed++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    logic [7:0] b;
    logic [1:0] mode;
    logic       pbit;
    logic       stopv;
    int         ones;
    int         gap;

    rst_n    = 1'b0;
    rx_i     = 1'b1;
    parity_i = 2'd0;
    repeat (3) @(posedge baud_clk);
    #1;
    check("reset_data", 32'(data_o), 32'h00);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_parity_err", 32'(parity_err_o), 32'd0);
    check("reset_frame_err", 32'(frame_err_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    idle(2);

    send_frame(8'h55, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("busy_after_frame", 32'(busy_o), 32'd0);

    send_frame(8'hA3, 2'd1, 1'b1, 1'b1, 1'b0);
    idle(1);
    send_frame(8'hA3, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Framing error followed by a long line break.
    send_frame(8'h0F, 2'd2, 1'b0, 1'b0, 1'b0);
    repeat (40) drive_bit(1'b0);
    idle(2);
    check("busy_after_break", 32'(busy_o), 32'd0);
    send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Short low glitch in idle.
    rx_i = 1'b0;
    repeat (4) @(posedge baud_clk);
    #1;
    rx_i = 1'b1;
    check("busy_on_glitch", 32'(busy_o), 32'd1);
    repeat (M + 1) @(posedge baud_clk);
    #1;
    check("busy_after_false_start", 32'(busy_o), 32'd0);
    idle(2);

    send_frame(8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 2'd0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h81, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Reset in the middle of bit 4 of 0x3C; that frame must vanish.
    parity_i = 2'd0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx_i = 1'b1;
    repeat (M) @(posedge baud_clk);
    #2;
    rst_n     = 1'b0;
    hold_data = 8'h00;
    hold_perr = 1'b0;
    hold_ferr = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy_o), 32'd0);
    check("async_reset_data", 32'(data_o), 32'h00);
    check("async_reset_valid", 32'(valid_o), 32'd0);
    repeat (OS - M) @(posedge baud_clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send_frame(8'hC3, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(2);

    for (int n = 0; n < 24; n++) begin
      b     = 8'($urandom);
      mode  = 2'($urandom_range(0, 3));
      ones  = $countones(b);
      pbit  = (mode == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1);
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stopv = ($urandom_range(0, 7) != 0);
      send_frame(b, mode, pbit, stopv, 1'b1);
      gap = $urandom_range(stopv ? 0 : 1, 2);
      if (gap > 0) idle(gap);
    end
    idle(3);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("busy_final", 32'(busy_o), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud_clk cycles per UART bit period (legal: 8-32, even).
REQ-002 baud_clk  input  1  oversampling clock (OVERSAMPLE x bit rate); all state on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 parity_i  input  2  0 none, 1 odd, 2 even, 3 treated as none.
REQ-005 rx_i  input  1  serial line, idle high, asynchronous to baud_clk.
REQ-006 data_o  output  8  last received data byte.
REQ-007 valid_o  output  1  one-cycle pulse: data_o, parity_err_o, frame_err_o updated this cycle.
REQ-008 parity_err_o  output  1  parity mismatch on last frame.
REQ-009 frame_err_o  output  1  stop bit sampled low on last frame.
REQ-010 busy_o  output  1  high whenever state != IDLE.

Function
REQ-011 rx_i SHALL pass through a 2-flop synchronizer (sync reset value 1); all logic uses the synchronized signal rxs.
REQ-012 Frame: start(0), 8 data bits LSB first, optional parity bit, stop(1).
REQ-013 States: IDLE, START, DATA, PARITY, STOP; tick counter 0..OVERSAMPLE-1 and 3-bit bit index.
REQ-014 IDLE -> START on falling edge of rxs (previous rxs 1, current 0); tick counter cleared to 0 in the cycle the edge is seen.
REQ-015 Each bit SHALL be decided by majority vote of rxs at ticks M-1, M, M+1 (M = OVERSAMPLE/2), decision made at tick M+1.
REQ-016 START: vote 1 -> false start, return to IDLE at the decision cycle, no valid_o; vote 0 -> latch parity_i, continue; START/DATA/PARITY advance to next bit at tick OVERSAMPLE-1.
REQ-017 DATA: vote shifted in LSB first; after bit index 7 go to PARITY if latched parity is 1 or 2, else STOP.
REQ-018 Parity expected: odd -> ~^data (data+parity has odd ones); even -> ^data; parity_err = vote != expected; 0 when no parity.
REQ-019 STOP: at decision tick SHALL pulse valid_o, load data_o, parity_err_o, frame_err_o (= ~vote), and return to IDLE in the same cycle (half-bit early resync).
REQ-020 After frame error, IDLE SHALL require rxs to go high before a new falling edge is accepted (line break produces exactly one valid_o).
REQ-021 data_o and error outputs SHALL hold between valid_o pulses; valid_o never high two consecutive cycles.
REQ-022 parity_i changes mid-frame SHALL not affect the current frame.
REQ-023 Latency: valid_o asserts 2 + (9 or 10)*OVERSAMPLE + M + 1 cycles after the rx_i falling edge (10 with parity), +/-1 for synchronizer phase.
REQ-024 Frame with 1-cycle stop bit gap between back-to-back frames SHALL be received without loss.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer 1, data_o 0x00, valid_o 0, parity_err_o 0, frame_err_o 0, busy_o 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new falling edge.

Verification
REQ-027 parity_i=0, send 0x55, OVERSAMPLE=16 -> one valid_o, data_o=0x55, both errors 0, busy_o low after.
REQ-028 parity_i=1, send 0xA3 with parity bit 1 -> data_o=0xA3, parity_err_o=0; same byte with parity bit 0 -> parity_err_o=1.
REQ-029 parity_i=2, send 0x0F with stop bit driven 0 -> valid_o, data_o=0x0F, frame_err_o=1; line held low 40 bit times -> no further valid_o until line high then new start.
REQ-030 rx_i low glitch of 4 cycles in IDLE -> no valid_o, busy_o returns 0 at start decision.
REQ-031 Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid_o pulses, correct data each.
REQ-032 rst_n asserted during bit 4 of 0x3C, released, then 0xC3 sent -> single valid_o with data_o=0xC3, errors 0.
